// File: rtl/serial_alu_pkg.sv
// Shared types and constants for the bit-serial add/subtract unit.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fa_bit.sv
// Single-bit full adder cell shared by every bit position of the serial datapath.
module fa_bit (
  input  logic inA,
  input  logic inB,
  input  logic cin,
  output logic y,
  output logic cout
);

  assign y    = inA ^ inB ^ cin;
  assign cout = (inA & inB) | (inA & cin) | (inB & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: walks both operands LSB-first through one full-adder
// cell and reports result, carry, signed overflow and zero once all bits are done.
module serial_addsub
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_aSh;
  logic [WIDTH-1:0] r_bSh;
  logic [WIDTH-2:0] r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_count;

  logic             w_sum;
  logic             w_carryNext;
  logic [WIDTH-1:0] w_resultNext;
  logic             w_cMsbIn;

  fa_bit u_fa (
    .inA  (r_aSh[0]),
    .inB  (r_bSh[0]),
    .cin  (r_carry),
    .y    (w_sum),
    .cout (w_carryNext)
  );

  // The new sum bit enters at the MSB; on the last bit this is the full result.
  assign w_resultNext = {w_sum, r_acc};
  assign w_cMsbIn     = r_carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_aSh     <= '0;
      r_bSh     <= '0;
      r_acc     <= '0;
      r_carry   <= 1'b0;
      r_count   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            // Subtraction is a + ~b + 1, with the +1 entering as the initial carry.
            r_aSh   <= a;
            r_bSh   <= (sub == OP_SUB) ? ~b : b;
            r_carry <= sub;
            r_count <= '0;
            r_acc   <= '0;
            r_state <= RUN;
            busy    <= 1'b1;
          end else begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        RUN: begin
          r_carry <= w_carryNext;
          r_aSh   <= r_aSh >> 1;
          r_bSh   <= r_bSh >> 1;
          r_acc   <= w_resultNext[WIDTH-1:1];
          r_count <= r_count + 1'b1;
          if (r_count == LAST_BIT) begin
            // Signed overflow: carry into the MSB differs from carry out of it.
            r_state   <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            result    <= w_resultNext;
            carry_out <= w_carryNext;
            overflow  <= w_cMsbIn ^ w_carryNext;
            zero      <= (w_resultNext == '0);
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
